// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls/bubbles, EXE-resolved branch/JALR redirects
// held across memory stalls, and saturating redirect/load-use event counters.
module hazard_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Istall,
    input  logic              Dstall,
    input  logic [4:0]        rs1_addr_ID,
    input  logic [4:0]        rs2_addr_ID,
    input  logic              rs1_used_ID,
    input  logic              rs2_used_ID,
    input  logic [4:0]        rd_addr_EXE,
    input  logic              mem_read_EXE,
    input  logic              branch_taken_EXE,
    input  logic [DATA_W-1:0] branch_target_EXE,
    input  logic              jalr_EXE,
    input  logic [DATA_W-1:0] jalr_target_EXE,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              bubble_ID_EXE,
    output logic              flush,
    output logic              flush_jalr,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic [CNT_W-1:0]  loaduse_cnt
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StPendBr   = 2'd1,
        StPendJalr = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_pend_pc;
    logic [CNT_W-1:0]  r_redirect_cnt;
    logic [CNT_W-1:0]  r_loaduse_cnt;

    logic w_stall;
    logic w_run;
    logic w_pend_br;
    logic w_pend_jalr;
    logic w_fresh_jalr;
    logic w_fresh_br;
    logic w_flush;
    logic w_flush_jalr;
    logic w_redirect;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_lu;
    logic w_lu_eff;
    logic w_bubble;
    logic [DATA_W-1:0] w_redirect_pc;

    assign w_stall     = Istall | Dstall;
    assign w_run       = (r_state == StRun);
    assign w_pend_br   = (r_state == StPendBr);
    assign w_pend_jalr = (r_state == StPendJalr);

    // JALR takes priority over a simultaneous taken branch.
    assign w_fresh_jalr = jalr_EXE & w_run;
    assign w_fresh_br   = branch_taken_EXE & ~jalr_EXE & w_run;

    assign w_flush      = (w_fresh_br | w_pend_br) & ~w_stall;
    assign w_flush_jalr = (w_fresh_jalr | w_pend_jalr) & ~w_stall;
    assign w_redirect   = w_flush | w_flush_jalr;

    always_comb begin
        w_redirect_pc = '0;
        if (w_pend_br || w_pend_jalr) begin
            w_redirect_pc = r_pend_pc;
        end else if (w_fresh_jalr) begin
            w_redirect_pc = jalr_target_EXE;
        end else if (w_fresh_br) begin
            w_redirect_pc = branch_target_EXE;
        end
    end

    assign w_rs1_hit = rs1_used_ID & (rs1_addr_ID == rd_addr_EXE);
    assign w_rs2_hit = rs2_used_ID & (rs2_addr_ID == rd_addr_EXE);
    assign w_lu      = mem_read_EXE & (rd_addr_EXE != 5'd0) & (w_rs1_hit | w_rs2_hit);

    // The ID instruction is wrong-path whenever a redirect is in flight.
    assign w_lu_eff  = w_lu & ~w_redirect & w_run;
    assign w_bubble  = w_lu_eff & ~w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StRun;
            r_pend_pc <= '0;
        end else begin
            case (r_state)
                StRun: begin
                    if (w_fresh_jalr && w_stall) begin
                        r_state   <= StPendJalr;
                        r_pend_pc <= jalr_target_EXE;
                    end else if (w_fresh_br && w_stall) begin
                        r_state   <= StPendBr;
                        r_pend_pc <= branch_target_EXE;
                    end
                end
                StPendBr, StPendJalr: begin
                    if (!w_stall) begin
                        r_state <= StRun;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_cnt <= '0;
            r_loaduse_cnt  <= '0;
        end else begin
            if (w_redirect && !(&r_redirect_cnt)) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            end
            if (w_bubble && !(&r_loaduse_cnt)) begin
                r_loaduse_cnt <= r_loaduse_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_hold        = w_stall | w_lu_eff;
    assign if_id_hold     = w_stall | w_lu_eff;
    assign bubble_ID_EXE  = w_bubble;
    assign flush          = w_flush;
    assign flush_jalr     = w_flush_jalr;
    assign redirect_valid = w_redirect;
    assign redirect_pc    = w_redirect_pc;
    assign state_o        = r_state;
    assign redirect_cnt   = r_redirect_cnt;
    assign loaduse_cnt    = r_loaduse_cnt;

endmodule
